// File: rtl/alu_wide_seq.sv
// Wide ALU sequencer: runs one NIBBLES*4-bit command through a 4-bit ALU, LS nibble first.
// Latency 2*NIBBLES cycles from accept to res_valid with a 1-cycle ALU; illegal ops finish next cycle.
// Backpressure: cmd_ready only in IDLE; res_valid held until res_ready. ALU_WIDE_SEQ_TIMEOUT_EN adds a no-answer abort.
module alu_wide_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_op,
    input  logic [4*NIBBLES-1:0] cmd_a,
    input  logic [4*NIBBLES-1:0] cmd_b,
    input  logic                 cmd_cin,
    output logic                 alu_valid_in,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic                 alu_cin,
    output logic [3:0]           alu_ctl,
    input  logic                 alu_valid_out,
    input  logic [3:0]           alu_result,
    input  logic                 alu_carry,
    input  logic                 alu_zero,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*NIBBLES-1:0] res_data,
    output logic                 res_carry,
    output logic                 res_zero,
    output logic                 res_err
);

    localparam int W  = 4 * NIBBLES;
    localparam int KW = $clog2(NIBBLES);
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    localparam logic [3:0] OP_INC   = 4'd1;
    localparam logic [3:0] OP_DEC   = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_ADD_C = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_SUB_B = 4'd6;
    localparam logic [3:0] OP_SHL   = 4'd10;
    localparam logic [3:0] OP_SHR   = 4'd11;
    localparam logic [3:0] OP_ROL   = 4'd12;
    localparam logic [3:0] OP_ROR   = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [3:0]      r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_cin;
    logic [KW-1:0]   r_k;
    logic            r_carry;
    logic [W-1:0]    r_res;
    logic            r_res_carry;
    logic            r_zero;
    logic            r_err;

    logic            w_accept;
    logic            w_illegal;
    logic            w_capture;
    logic            w_last;
    logic            w_timeout;
    logic            w_first;
    logic            w_drive;
    logic            w_is_arith;
    logic            w_is_shift;
    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [W-1:0]    w_shl;
    logic [W-1:0]    w_shr;
    logic [3:0]      w_nib_cap;
    logic [W-1:0]    w_res_nxt;

    assign w_accept   = cmd_valid && (r_state == S_IDLE);
    assign w_illegal  = (cmd_op > OP_ROR);
    assign w_capture  = (r_state == S_WAIT) && alu_valid_out;
    assign w_last     = (r_k == K_LAST);
    assign w_first    = (r_k == '0);
    assign w_drive    = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_is_arith = (r_op >= OP_INC) && (r_op <= OP_SUB_B);
    assign w_is_shift = (r_op >= OP_SHL);

    assign w_a_nib = r_a[{r_k, 2'b00} +: 4];
    assign w_b_nib = r_b[{r_k, 2'b00} +: 4];

    // Whole-word shifts; nibble k only borrows its boundary bit from these.
    assign w_shl = {r_a[W-2:0], (r_op == OP_ROL) & r_a[W-1]};
    assign w_shr = {(r_op == OP_ROR) & r_a[0], r_a[W-1:1]};

`ifdef ALU_WIDE_SEQ_TIMEOUT_EN
    logic [2:0] r_tmo_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == S_WAIT) && !alu_valid_out) begin
            r_tmo_cnt <= r_tmo_cnt + 3'd1;
        end
    end

    // Fourth silent WAIT cycle after the issue pulse gives up on the ALU.
    assign w_timeout = (r_state == S_WAIT) && !alu_valid_out && (r_tmo_cnt == 3'd3);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_illegal ? S_DONE : S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_capture) begin
                    w_state_nxt = w_last ? S_DONE : S_ISSUE;
                end else if (w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  if (res_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-nibble ALU command; carry chains from the previous nibble's captured carry.
    always_comb begin
        alu_valid_in = (r_state == S_ISSUE);
        alu_a        = '0;
        alu_b        = '0;
        alu_cin      = 1'b0;
        alu_ctl      = '0;
        if (w_drive) begin
            alu_ctl = r_op;
            alu_a   = w_a_nib;
            alu_b   = w_b_nib;
            case (r_op)
                OP_ADD: begin
                    alu_ctl = w_first ? OP_ADD : OP_ADD_C;
                    alu_cin = w_first ? 1'b0 : r_carry;
                end
                OP_ADD_C: alu_cin = w_first ? r_cin : r_carry;
                OP_SUB: begin
                    alu_ctl = w_first ? OP_SUB : OP_SUB_B;
                    alu_cin = w_first ? 1'b0 : r_carry;
                end
                OP_SUB_B: alu_cin = w_first ? r_cin : r_carry;
                OP_INC: begin
                    alu_ctl = OP_ADD_C;
                    alu_a   = '0;
                    alu_b   = w_b_nib;
                    alu_cin = w_first ? 1'b1 : r_carry;
                end
                OP_DEC: begin
                    alu_ctl = OP_SUB_B;
                    alu_a   = w_b_nib;
                    alu_b   = '0;
                    alu_cin = w_first ? 1'b1 : r_carry;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_nib_cap = alu_result;
        if ((r_op == OP_SHL) || (r_op == OP_ROL)) begin
            w_nib_cap[0] = w_shl[{r_k, 2'b00}];
        end else if ((r_op == OP_SHR) || (r_op == OP_ROR)) begin
            w_nib_cap[3] = w_shr[{r_k, 2'b11}];
        end
        w_res_nxt = r_res;
        w_res_nxt[{r_k, 2'b00} +: 4] = w_nib_cap;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_k         <= '0;
            r_carry     <= 1'b0;
            r_res       <= '0;
            r_res_carry <= 1'b0;
            r_zero      <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            r_op        <= cmd_op;
            r_a         <= cmd_a;
            r_b         <= cmd_b;
            r_cin       <= cmd_cin;
            r_k         <= '0;
            r_carry     <= 1'b0;
            r_res       <= '0;
            r_res_carry <= 1'b0;
            r_zero      <= 1'b1;
            r_err       <= w_illegal;
        end else if (w_capture) begin
            r_res   <= w_res_nxt;
            r_carry <= alu_carry;
            // Shift zero must reflect the patched boundary bits, not the ALU's view.
            r_zero  <= w_is_shift ? (w_res_nxt == '0) : (r_zero & alu_zero);
            if (w_last) begin
                r_res_carry <= w_is_arith & alu_carry;
            end else begin
                r_k <= r_k + 1'b1;
            end
        end else if (w_timeout) begin
            r_res       <= '0;
            r_res_carry <= 1'b0;
            r_zero      <= 1'b0;
            r_err       <= 1'b1;
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign res_valid = (r_state == S_DONE);
    assign res_data  = r_res;
    assign res_carry = r_res_carry;
    assign res_zero  = r_zero;
    assign res_err   = r_err;

endmodule
